// File: rtl/scandoubler_ctl.sv
// Scandoubler mode sequencer: measures input timing, declares lock,
// and switches doubling/hq2x only at vertical blank behind a muted window.
module scandoubler_ctl #(
  parameter int LENGTH        = 768,
  parameter int MUTE_FRAMES   = 2,
  parameter int STABLE_FRAMES = 3,
  parameter int WD_BITS       = 22
) (
  input  logic        clk_vid,
  input  logic        reset_n,
  input  logic        ce_pix,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        hb_in,
  input  logic        vb_in,
  input  logic        req_en,
  input  logic        req_hq2x,
  output logic        sd_en,
  output logic        hq2x_en,
  output logic        blank_out,
  output logic        locked,
  output logic        fit,
  output logic        busy,
  output logic [11:0] h_total,
  output logic [11:0] h_active,
  output logic [10:0] v_total
);

  localparam int MUTE_N = (MUTE_FRAMES < 1) ? 1 : MUTE_FRAMES;
  localparam logic [7:0]  MUTE_INIT  = 8'(MUTE_N);
  localparam logic [3:0]  STABLE_MAX = 4'(STABLE_FRAMES);
  localparam logic [12:0] LEN_L      = 13'(LENGTH);
  localparam logic [WD_BITS-1:0] WD_ONE = {{(WD_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    RUN,
    WAIT_VB,
    MUTE
  } state_t;

  state_t state, state_nxt;

  logic hs_q, vs_q, vb_q;
  logic line_start, frame_start, vb_rise;

  logic [11:0] pix_cnt, act_cnt, pix_nxt, act_nxt;
  logic [10:0] line_cnt, line_nxt;
  logic [11:0] prev_h;
  logic [10:0] prev_v;
  logic [3:0]  stable, stable_inc;
  logic        same;
  logic [WD_BITS-1:0] wd_cnt;

  logic       sd_tgt, hq_tgt, tgt_eq;
  logic       sd_nxt, hq_nxt, blank_nxt;
  logic [7:0] mute_cnt, mute_nxt;

  assign line_start  = hs_q & ~hs_in;
  assign frame_start = ~vs_q & vs_in;
  assign vb_rise     = ~vb_q & vb_in;

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      vb_q <= 1'b0;
    end else begin
      hs_q <= hs_in;
      vs_q <= vs_in;
      vb_q <= vb_in;
    end
  end

  always_comb begin
    pix_nxt  = pix_cnt;
    act_nxt  = act_cnt;
    line_nxt = line_cnt;
    if (ce_pix && pix_cnt != '1)
      pix_nxt = pix_cnt + 12'd1;
    if (ce_pix && !hb_in && act_cnt != '1)
      act_nxt = act_cnt + 12'd1;
    if (line_start && line_cnt != '1)
      line_nxt = line_cnt + 11'd1;
  end

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt  <= '0;
      act_cnt  <= '0;
      h_total  <= '0;
      h_active <= '0;
      fit      <= 1'b0;
    end else if (line_start) begin
      h_total  <= pix_nxt;
      h_active <= act_nxt;
      fit      <= ({1'b0, act_nxt} <= LEN_L);
      pix_cnt  <= '0;
      act_cnt  <= '0;
    end else begin
      pix_cnt <= pix_nxt;
      act_cnt <= act_nxt;
    end
  end

  // A line ending on the frame-start cycle belongs to the old frame.
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      line_cnt <= '0;
      v_total  <= '0;
    end else if (frame_start) begin
      v_total  <= line_nxt;
      line_cnt <= '0;
    end else begin
      line_cnt <= line_nxt;
    end
  end

  assign same = (h_total == prev_h) && (line_nxt == prev_v) &&
                (h_total != '1) && (line_nxt != '1);
  assign stable_inc = (stable >= STABLE_MAX) ? STABLE_MAX
                                             : stable + 4'd1;

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      prev_h <= '0;
      prev_v <= '0;
      stable <= '0;
      locked <= 1'b0;
      wd_cnt <= '0;
    end else if (frame_start) begin
      wd_cnt <= '0;
      prev_h <= h_total;
      prev_v <= line_nxt;
      if (same) begin
        stable <= stable_inc;
        if (stable_inc == STABLE_MAX)
          locked <= 1'b1;
      end else begin
        stable <= '0;
        locked <= 1'b0;
      end
    end else if (wd_cnt == '1) begin
      stable <= '0;
      locked <= 1'b0;
    end else begin
      wd_cnt <= wd_cnt + WD_ONE;
    end
  end

  assign sd_tgt = req_en & locked & fit;
  assign hq_tgt = req_hq2x & sd_tgt;
  assign tgt_eq = ({sd_tgt, hq_tgt} == {sd_en, hq2x_en});
  assign busy   = (state != RUN);

  always_comb begin
    state_nxt = state;
    sd_nxt    = sd_en;
    hq_nxt    = hq2x_en;
    blank_nxt = blank_out;
    mute_nxt  = mute_cnt;
    unique case (state)
      RUN: begin
        if (!tgt_eq)
          state_nxt = WAIT_VB;
      end
      WAIT_VB: begin
        if (tgt_eq) begin
          state_nxt = RUN;
        end else if (vb_rise) begin
          blank_nxt = 1'b1;
          sd_nxt    = sd_tgt;
          hq_nxt    = hq_tgt;
          mute_nxt  = MUTE_INIT;
          state_nxt = MUTE;
        end
      end
      MUTE: begin
        if (frame_start) begin
          if (mute_cnt <= 8'd1) begin
            mute_nxt  = '0;
            blank_nxt = 1'b0;
            state_nxt = RUN;
          end else begin
            mute_nxt = mute_cnt - 8'd1;
          end
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      sd_en     <= 1'b0;
      hq2x_en   <= 1'b0;
      blank_out <= 1'b0;
      mute_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      sd_en     <= sd_nxt;
      hq2x_en   <= hq_nxt;
      blank_out <= blank_nxt;
      mute_cnt  <= mute_nxt;
    end
  end

endmodule

// File: doc/scandoubler_ctl.md
Name: scandoubler_ctl

Overview:
Mode sequencer and input-timing monitor placed in front of the scandoubler/Hq2x datapath. It measures incoming line and frame geometry and declares lock once the timing is stable. It decides whether doubling is enabled and whether hq2x is used. Mode changes are applied only at vertical blank, with output muted for a fixed number of frames, so the line buffer never sees a mid-frame reconfiguration or a line longer than it can hold.

Parameters:
LENGTH, 768, max active pixels per line the scandoubler line buffer holds
MUTE_FRAMES, 2, frames of forced blank after a mode switch (0 treated as 1)
STABLE_FRAMES, 3, consecutive identical frames required to assert lock (1..15)

Ports:
clk_vid  in  1  video clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
ce_pix  in  1  input pixel enable (level, one clk_vid per pixel)
hs_in  in  1  input hsync, active high
vs_in  in  1  input vsync, active high
hb_in  in  1  input hblank
vb_in  in  1  input vblank
req_en  in  1  user request: scandoubler on
req_hq2x  in  1  user request: hq2x filter (meaningful only with req_en)
sd_en  out  1  scandoubler output selected
hq2x_en  out  1  drives scandoubler hq2x input
blank_out  out  1  force downstream video to black
locked  out  1  input timing stable
fit  out  1  last measured active width <= LENGTH
busy  out  1  mode switch in progress (state != RUN)
h_total  out  12  ce_pix count per line, last complete line
h_active  out  12  ce_pix count with hb_in low, last complete line
v_total  out  11  lines per frame, last complete frame

Behaviour:
- Reset (async, reset_n low): all outputs 0; state RUN; all counters, stable count and edge-detect registers 0.
- Edges: registered copies of hs_in, vs_in and vb_in. Line start = hs_in falling edge. Frame start = vs_in rising edge. Edge pulses are 1 cycle, detected 1 cycle after the input pin transition.
- Line counters: pix cnt increments on ce_pix; act cnt increments on ce_pix & ~hb_in. Both saturate at 4095.
- On a line-start pulse: h_total <= pix cnt and h_active <= act cnt (the value includes a ce_pix in the same cycle); both counters restart from 0. fit <= (act cnt <= LENGTH), registered the same cycle.
- Line counter: increments on each line-start pulse, saturates at 2047.
- On a frame-start pulse: v_total <= line count and the counter clears. If line start and frame start coincide, that line is counted in the old frame.
- Lock, evaluated on each frame-start pulse:
  - If h_total and v_total equal the previous frame's values and neither is saturated, stable cnt increments, saturating at STABLE_FRAMES.
  - Otherwise stable cnt <= 0 and locked <= 0.
  - locked <= 1 when stable cnt reaches STABLE_FRAMES.
  - Watchdog: 2^22 clk_vid cycles without a frame start forces locked <= 0 and stable cnt <= 0.
- Targets (combinational): sd_tgt = req_en & locked & fit; hq_tgt = req_hq2x & sd_tgt.
- State machine:
  - RUN: busy = 0. If {sd_tgt, hq_tgt} != {sd_en, hq2x_en}, go to WAIT_VB.
  - WAIT_VB: wait for a vb_in rising edge. On the edge: blank_out <= 1; {sd_en, hq2x_en} <= current {sd_tgt, hq_tgt}; mute cnt <= max(MUTE_FRAMES, 1); go to MUTE. If the targets return to the current outputs before the edge, go back to RUN with no change.
  - MUTE: each frame-start pulse decrements mute cnt. A frame start in the same cycle as the entering vb edge is not counted. When mute cnt reaches 0: blank_out <= 0, go to RUN. RUN re-evaluates the targets on the next cycle, so a request changed during MUTE causes a second switch.
- Lock loss while sd_en = 1 follows the normal path: WAIT_VB, then the switch applies at the next vb rise. sd_en never changes outside a vb rise edge cycle.
- hq2x_en is never 1 while sd_en is 0.
- Reset asserted mid-switch returns to reset values immediately. blank_out drops asynchronously.

Test Plan:
- Steady 800 ce_pix/line (640 active), 525 lines, req_en = 1 from reset -> h_total = 800, h_active = 640, v_total = 525. locked rises at the 4th frame start (compare 3 times). Then WAIT_VB; sd_en = 1 and blank_out = 1 at the next vb rise. blank_out clears at the 2nd subsequent frame start.
- Locked and sd_en = 1; toggle req_hq2x mid-frame -> hq2x_en unchanged until the vb rise, then 1. busy high from request until mute ends. sd_en stays 1.
- Active width 800 with LENGTH = 768 and req_en = 1 -> fit = 0; sd_en stays 0; state stays RUN.
- Locked and enabled, then v_total changes 525 -> 524 -> locked = 0 at that frame start. sd_en drops at the next vb rise with blank_out = 1. It re-enables after 3 stable frames plus a mute.
- Stop vs_in for 2^22 cycles -> locked = 0. Assert reset_n low during MUTE -> all outputs 0 the same cycle; after release, state RUN.
- vb rise and vs rise in the same cycle while in WAIT_VB -> mute lasts 2 further frame starts, not 1.
